// File: rtl/calc_seq_ctrl_if.sv
// Keypad / ALU / display bundle for the calculator sequencer.
// The slave modport is the sequencer side; master is the keypad + ALU + display side.
interface calc_seq_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  key_valid;
    logic [4:0]            key_code;
    logic                  key_ready;
    logic [4*DIGITS-1:0]   alu_num1;
    logic [4*DIGITS-1:0]   alu_num2;
    logic [2:0]            alu_op;
    logic [4*DIGITS-1:0]   alu_res;
    logic [4*DIGITS-1:0]   disp;
    logic                  busy;
    logic                  err;

    modport master (
        output key_valid, key_code, alu_res,
        input  key_ready, alu_num1, alu_num2, alu_op, disp, busy, err
    );

    modport slave (
        input  key_valid, key_code, alu_res,
        output key_ready, alu_num1, alu_num2, alu_op, disp, busy, err
    );
endinterface

// File: rtl/calc_seq_ctrl.sv
// Keypad-to-ALU sequencer: builds BCD operands, runs a fixed-latency ALU op, owns display and error flag.
// Define CALC_CHAIN_EN to make an operator key in operand-B entry evaluate and chain the next op.
module calc_seq_ctrl #(
    parameter int ALU_LATENCY = 2,
    parameter int DIGITS      = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    calc_seq_ctrl_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    localparam logic [CW-1:0] CNT_MAX     = CW'(DIGITS);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [3:0]    LAT_INIT    = 4'(ALU_LATENCY - 1);
    localparam logic [W-1:0]  ERR_PATTERN = {DIGITS{4'hE}};
    localparam logic [2:0]    OP_DIV      = 3'b011;

    localparam logic [2:0] ST_ENTRY_A = 3'd0;
    localparam logic [2:0] ST_ENTRY_B = 3'd1;
    localparam logic [2:0] ST_EXEC    = 3'd2;
    localparam logic [2:0] ST_SHOW    = 3'd3;
    localparam logic [2:0] ST_ERR     = 3'd4;

    localparam logic [2:0] K_NONE  = 3'd0;
    localparam logic [2:0] K_DIGIT = 3'd1;
    localparam logic [2:0] K_OP    = 3'd2;
    localparam logic [2:0] K_EQ    = 3'd3;
    localparam logic [2:0] K_CLR   = 3'd4;

    function automatic logic [2:0] key_to_op(input logic [4:0] code);
        logic [2:0] op;
        case (code)
            5'd10:   op = 3'b000;
            5'd11:   op = 3'b001;
            5'd12:   op = 3'b010;
            5'd13:   op = 3'b011;
            5'd14:   op = 3'b100;
            default: op = 3'b000;
        endcase
        return op;
    endfunction

    function automatic logic [W-1:0] shift_in(input logic [W-1:0] v, input logic [3:0] d);
        return {v[W-5:0], d};
    endfunction

    logic [2:0]    state_r, state_s;
    logic [W-1:0]  entry_r, entry_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [W-1:0]  a_r, a_s;
    logic [W-1:0]  b_r, b_s;
    logic [2:0]    op_r, op_s;
    logic [2:0]    pend_r, pend_s;
    logic [W-1:0]  res_r, res_s;
    logic          chain_r, chain_s;
    logic [3:0]    lat_r, lat_s;
    logic [W-1:0]  num1_r, num1_s;
    logic [W-1:0]  num2_r, num2_s;
    logic [2:0]    aop_r, aop_s;
    logic [W-1:0]  disp_r, disp_s;
    logic          busy_r, busy_s;
    logic          err_r, err_s;
    logic          ready_r, ready_s;

    logic [2:0]    kcls_s;
    logic [3:0]    digit_s;
    logic [2:0]    newop_s;
    logic [W-1:0]  shifted_s;
    logic          eq_go_s;
    logic          chain_req_s;
    logic          clr_s;

    assign digit_s   = bus.key_code[3:0];
    assign newop_s   = key_to_op(bus.key_code);
    assign shifted_s = shift_in(entry_r, digit_s);

    // Classify the key accepted on this edge; nothing is accepted while key_ready is low.
    always_comb begin
        kcls_s = K_NONE;
        if (bus.key_valid && ready_r) begin
            if (bus.key_code <= 5'd9) begin
                kcls_s = K_DIGIT;
            end else if (bus.key_code <= 5'd14) begin
                kcls_s = K_OP;
            end else if (bus.key_code == 5'd15) begin
                kcls_s = K_EQ;
            end else if (bus.key_code == 5'd16) begin
                kcls_s = K_CLR;
            end else begin
                kcls_s = K_NONE;
            end
        end else begin
            kcls_s = K_NONE;
        end
    end

    // Sequencer next-state: key handling per state, then the shared evaluate and clear paths.
    always_comb begin
        state_s     = state_r;
        entry_s     = entry_r;
        cnt_s       = cnt_r;
        a_s         = a_r;
        b_s         = b_r;
        op_s        = op_r;
        pend_s      = pend_r;
        res_s       = res_r;
        chain_s     = chain_r;
        lat_s       = lat_r;
        num1_s      = num1_r;
        num2_s      = num2_r;
        aop_s       = aop_r;
        disp_s      = disp_r;
        busy_s      = busy_r;
        err_s       = err_r;
        ready_s     = ready_r;
        eq_go_s     = 1'b0;
        chain_req_s = 1'b0;
        clr_s       = 1'b0;

        case (state_r)
            ST_ENTRY_A, ST_ENTRY_B: begin
                case (kcls_s)
                    K_DIGIT: begin
                        // A full operand swallows further digits instead of wrapping.
                        if (cnt_r < CNT_MAX) begin
                            entry_s = shifted_s;
                            cnt_s   = cnt_r + CNT_ONE;
                            disp_s  = shifted_s;
                        end else begin
                            entry_s = entry_r;
                        end
                    end
                    K_OP: begin
                        if (state_r == ST_ENTRY_A) begin
                            a_s     = entry_r;
                            op_s    = newop_s;
                            entry_s = '0;
                            cnt_s   = '0;
                            disp_s  = '0;
                            state_s = ST_ENTRY_B;
                        end else begin
`ifdef CALC_CHAIN_EN
                            eq_go_s     = 1'b1;
                            chain_req_s = 1'b1;
                            pend_s      = newop_s;
`else
                            op_s        = newop_s;
`endif
                        end
                    end
                    K_EQ: begin
                        if (state_r == ST_ENTRY_B) begin
                            eq_go_s = 1'b1;
                        end else begin
                            eq_go_s = 1'b0;
                        end
                    end
                    K_CLR:   clr_s   = 1'b1;
                    default: state_s = state_r;
                endcase
            end
            ST_EXEC: begin
                if (lat_r == 4'd0) begin
                    res_s   = bus.alu_res;
                    disp_s  = bus.alu_res;
                    busy_s  = 1'b0;
                    ready_s = 1'b1;
                    chain_s = 1'b0;
                    if (chain_r) begin
                        a_s     = bus.alu_res;
                        op_s    = pend_r;
                        state_s = ST_ENTRY_B;
                    end else begin
                        state_s = ST_SHOW;
                    end
                end else begin
                    lat_s = lat_r - 4'd1;
                end
            end
            ST_SHOW: begin
                case (kcls_s)
                    K_DIGIT: begin
                        entry_s = W'(digit_s);
                        cnt_s   = CNT_ONE;
                        disp_s  = W'(digit_s);
                        state_s = ST_ENTRY_A;
                    end
                    K_OP: begin
                        // Result becomes operand A; disp keeps showing it until B's first digit.
                        a_s     = res_r;
                        op_s    = newop_s;
                        state_s = ST_ENTRY_B;
                    end
                    K_CLR:   clr_s   = 1'b1;
                    default: state_s = state_r;
                endcase
            end
            ST_ERR: begin
                case (kcls_s)
                    K_CLR:   clr_s   = 1'b1;
                    default: state_s = state_r;
                endcase
            end
            default: clr_s = 1'b1;
        endcase

        // entry is cleared on evaluation so SHOW and chained ENTRY_B start B from empty.
        if (eq_go_s) begin
            b_s     = entry_r;
            entry_s = '0;
            cnt_s   = '0;
            if ((op_r == OP_DIV) && (entry_r == '0)) begin
                state_s = ST_ERR;
                err_s   = 1'b1;
                disp_s  = ERR_PATTERN;
            end else begin
                state_s = ST_EXEC;
                num1_s  = a_r;
                num2_s  = entry_r;
                aop_s   = op_r;
                busy_s  = 1'b1;
                ready_s = 1'b0;
                lat_s   = LAT_INIT;
                chain_s = chain_req_s;
            end
        end else if (clr_s) begin
            state_s = ST_ENTRY_A;
            entry_s = '0;
            cnt_s   = '0;
            a_s     = '0;
            b_s     = '0;
            op_s    = 3'b000;
            pend_s  = 3'b000;
            res_s   = '0;
            chain_s = 1'b0;
            lat_s   = 4'd0;
            disp_s  = '0;
            busy_s  = 1'b0;
            err_s   = 1'b0;
            ready_s = 1'b1;
        end else begin
            err_s = err_r;
        end
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_ENTRY_A;
            entry_r <= '0;
            cnt_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            op_r    <= 3'b000;
            pend_r  <= 3'b000;
            res_r   <= '0;
            chain_r <= 1'b0;
            lat_r   <= 4'd0;
            num1_r  <= '0;
            num2_r  <= '0;
            aop_r   <= 3'b000;
            disp_r  <= '0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            entry_r <= entry_s;
            cnt_r   <= cnt_s;
            a_r     <= a_s;
            b_r     <= b_s;
            op_r    <= op_s;
            pend_r  <= pend_s;
            res_r   <= res_s;
            chain_r <= chain_s;
            lat_r   <= lat_s;
            num1_r  <= num1_s;
            num2_r  <= num2_s;
            aop_r   <= aop_s;
            disp_r  <= disp_s;
            busy_r  <= busy_s;
            err_r   <= err_s;
            ready_r <= ready_s;
        end
    end

    assign bus.key_ready = ready_r;
    assign bus.alu_num1  = num1_r;
    assign bus.alu_num2  = num2_r;
    assign bus.alu_op    = aop_r;
    assign bus.disp      = disp_r;
    assign bus.busy      = busy_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Bench for calc_seq_ctrl: directed test-plan steps plus random key streams against a behavioural calculator model.
// Honours CALC_CHAIN_EN the same way the design does.
module tb_calc_seq_ctrl;
    localparam int L = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    calc_seq_ctrl_if #(.DIGITS(4)) bus ();
    calc_seq_ctrl #(.ALU_LATENCY(L), .DIGITS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef enum {M_A, M_B, M_EXEC, M_SHOW, M_ERR} mst_t;
    mst_t        m_st;
    int          m_entry, m_cnt, m_op, m_pend;
    logic [15:0] m_a, m_b, m_res, m_disp, m_num1, m_num2;
    logic [2:0]  m_aop;
    logic        m_err;
    bit          m_chain;

    bit          hold_en = 1'b0;
    int          hold_code = 0;
    bit          ovr_en = 1'b0;
    logic [15:0] ovr_val = 16'h0;

    function automatic int bcd2int(input logic [15:0] v);
        return v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    // Reference ALU: decimal arithmetic modulo 10000.
    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        int ia, ib, r;
        ia = bcd2int(a);
        ib = bcd2int(b);
        case (op)
            3'd0: r = ia + ib;
            3'd1: r = ia - ib;
            3'd2: r = ia * ib;
            3'd3: r = (ib == 0) ? 0 : ia / ib;
            3'd4: begin
                r = 1;
                for (int i = 0; i < ib; i++) r = (r * ia) % 10000;
            end
            default: r = 0;
        endcase
        r = ((r % 10000) + 10000) % 10000;
        return int2bcd(r);
    endfunction

    // ALU stand-in: result only becomes valid L-1 falling edges after its inputs last changed.
    logic [34:0] alu_prev = '1;
    int          alu_stab = 0;
    logic [15:0] alu_good = 16'h0;
    always @(negedge clk) begin
        if ({bus.alu_num1, bus.alu_num2, bus.alu_op} !== alu_prev) begin
            alu_prev = {bus.alu_num1, bus.alu_num2, bus.alu_op};
            alu_good = alu_f(bus.alu_num1, bus.alu_num2, bus.alu_op);
            alu_stab = 0;
        end else if (alu_stab < 100) begin
            alu_stab = alu_stab + 1;
        end
        bus.alu_res = ovr_en ? ovr_val : ((alu_stab >= L - 1) ? alu_good : 16'hDEAD);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".disp"}, 32'(bus.disp), 32'(m_disp));
        check({tag, ".err"}, 32'(bus.err), 32'(m_err));
        check({tag, ".busy"}, 32'(bus.busy), 32'(m_st == M_EXEC));
        check({tag, ".key_ready"}, 32'(bus.key_ready), 32'(m_st != M_EXEC));
        check({tag, ".alu_num1"}, 32'(bus.alu_num1), 32'(m_num1));
        check({tag, ".alu_num2"}, 32'(bus.alu_num2), 32'(m_num2));
        check({tag, ".alu_op"}, 32'(bus.alu_op), 32'(m_aop));
    endtask

    task automatic model_reset(input bit keep_alu);
        m_st = M_A; m_entry = 0; m_cnt = 0; m_op = 0; m_pend = 0;
        m_a = 16'h0; m_b = 16'h0; m_res = 16'h0; m_disp = 16'h0;
        m_err = 1'b0; m_chain = 1'b0;
        if (!keep_alu) begin
            m_num1 = 16'h0; m_num2 = 16'h0; m_aop = 3'd0;
        end
    endtask

    task automatic go_eq(input bit chain);
        m_b = int2bcd(m_entry);
        m_entry = 0;
        m_cnt = 0;
        if (m_op == 3 && m_b == 16'h0) begin
            m_st = M_ERR; m_err = 1'b1; m_disp = 16'hEEEE;
        end else begin
            m_st = M_EXEC; m_num1 = m_a; m_num2 = m_b; m_aop = 3'(m_op); m_chain = chain;
        end
    endtask

    task automatic model_key(input int code);
        if (code == 16) begin
            model_reset(1'b1);
        end else if (code < 16) begin
            case (m_st)
                M_A, M_B: begin
                    if (code <= 9) begin
                        if (m_cnt < 4) begin
                            m_entry = m_entry * 10 + code;
                            m_cnt++;
                            m_disp = int2bcd(m_entry);
                        end
                    end else if (code == 15) begin
                        if (m_st == M_B) go_eq(1'b0);
                    end else if (m_st == M_A) begin
                        m_a = int2bcd(m_entry); m_op = code - 10;
                        m_entry = 0; m_cnt = 0; m_disp = 16'h0; m_st = M_B;
                    end else begin
`ifdef CALC_CHAIN_EN
                        m_pend = code - 10;
                        go_eq(1'b1);
`else
                        m_op = code - 10;
`endif
                    end
                end
                M_SHOW: begin
                    if (code <= 9) begin
                        m_entry = code; m_cnt = 1; m_disp = int2bcd(code); m_st = M_A;
                    end else if (code <= 14) begin
                        m_a = m_res; m_op = code - 10; m_st = M_B;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Walks an operation through its latency window, then applies the capture to the model.
    task automatic finish_exec();
        if (hold_en) begin
            bus.key_valid = 1'b1;
            bus.key_code = 5'(hold_code);
        end
        for (int i = 0; i < L; i++) begin
            check_all("exec");
            @(negedge clk);
        end
        m_res = alu_f(m_num1, m_num2, m_aop);
        m_disp = m_res;
        if (m_chain) begin
            m_a = m_res; m_op = m_pend; m_st = M_B; m_chain = 1'b0;
        end else begin
            m_st = M_SHOW;
        end
        check_all("capture");
    endtask

    // Called at a falling edge; offers the key until taken, then checks the outcome.
    task automatic press(input int code, input bit run_exec);
        int g;
        g = 0;
        bus.key_valid = 1'b1;
        bus.key_code = 5'(code);
        while (bus.key_ready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) check("key_ready_timeout", 32'(bus.key_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.key_valid = 1'b0;
        model_key(code);
        if (m_st == M_EXEC && run_exec) finish_exec();
        else check_all($sformatf("key%0d", code));
    endtask

    function automatic int ch2code(input byte c);
        case (c)
            "+": return 10;
            "-": return 11;
            "*": return 12;
            "/": return 13;
            "^": return 14;
            "=": return 15;
            "C": return 16;
            "R": return 20;
            default: return int'(c) - int'("0");
        endcase
    endfunction

    task automatic press_str(input string s);
        for (int i = 0; i < s.len(); i++) press(ch2code(s[i]), 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, code;
        bus.key_valid = 1'b0;
        bus.key_code = 5'd0;
        model_reset(1'b0);
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk);

        press_str("5000+4000=");
        check("tp1_num1", 32'(bus.alu_num1), 32'h5000);
        check("tp1_disp", 32'(bus.disp), 32'h9000);

        press_str("C9999-8999=");
        check("tp2_disp", 32'(bus.disp), 32'h1000);
        press_str("C12345");
        check("tp2_cap", 32'(bus.disp), 32'h1234);

        press_str("C8/0=+");
        check("tp3_err", 32'(bus.err), 32'd1);
        check("tp3_disp", 32'(bus.disp), 32'hEEEE);
        press_str("C");
        check("tp3_clr", 32'({bus.err, bus.disp}), 32'd0);

        press_str("14/7");
        hold_en = 1'b1;
        hold_code = 10;
        press(15, 1'b1);
        hold_en = 1'b0;
        press(10, 1'b1);
        check("tp4_disp", 32'(bus.disp), 32'h0002);
        press_str("3=");
        check("tp4_sum", 32'(bus.disp), 32'h0005);

        press_str("C2*1000+");
`ifdef CALC_CHAIN_EN
        check("tp5_chain_disp", 32'(bus.disp), 32'h2000);
`else
        check("tp5_plain_disp", 32'(bus.disp), 32'h1000);
`endif
        press_str("=");

        press_str("C12R3");
        check("reserved", 32'(bus.disp), 32'h0123);

        press_str("C3+4");
        press(15, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset(1'b0);
        check_all("rst_exec");
        ovr_en = 1'b1;
        ovr_val = 16'h4321;
        repeat (4) @(negedge clk);
        check_all("rst_exec_late");
        ovr_en = 1'b0;

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (m_st == M_ERR && r < 40) code = 16;
            else if (r < 55) code = $urandom_range(0, 9);
            else if (r < 75) code = $urandom_range(10, 14);
            else if (r < 88) code = 15;
            else if (r < 91) code = 16;
            else if (r < 95) code = $urandom_range(17, 31);
            else code = $urandom_range(0, 9);
            press(code, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
